// File: rtl/vram_controller.sv
// Video RAM front end: CPU/fill arbitration onto the single write port and scan-to-address read path.
// Fill engine is built only when VRAM_FILL_EN is defined; otherwise every CPU request is a write.
//
// state | meaning
// IDLE  | no fill; CPU owns every write slot
// FILL  | screen fill running; slot alternates CPU/fill under contention
module vram_controller #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iCpuValid,
    input  logic [ADDR_WIDTH-1:0]   iCpuAddr,
    input  logic [DATA_WIDTH-1:0]   iCpuData,
    output logic                    oCpuReady,
    input  logic                    iFillStart,
    input  logic [DATA_WIDTH-1:0]   iFillColor,
    output logic                    oFillBusy,
    output logic                    oFillDone,
    input  logic [ADDR_WIDTH/2-1:0] iPixelX,
    input  logic [ADDR_WIDTH/2-1:0] iPixelY,
    input  logic                    iPixelValid,
    output logic                    oPixelValid,
    output logic                    oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0]   oRamWriteAddress,
    output logic [DATA_WIDTH-1:0]   oRamDataIn,
    output logic [ADDR_WIDTH-1:0]   oRamReadAddress
);

    logic                  slot_we;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic [DATA_WIDTH-1:0] slot_data;
    logic                  pix_valid_d;

`ifdef VRAM_FILL_EN
    typedef enum logic {IDLE, FILL} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] rFillAddr, fill_addr_next;
    logic [DATA_WIDTH-1:0] rFillColor, fill_color_next;
    logic                  rLastFill, last_fill_next;
    logic                  fill_done_next;
    logic                  cpu_accept;

    // Ready comes from registers only so the CPU side never sees a combinational loop.
    assign oCpuReady  = (state == IDLE) | rLastFill;
    assign cpu_accept = iCpuValid & oCpuReady;
    assign oFillBusy  = (state == FILL);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            rFillAddr  <= '0;
            rFillColor <= '0;
            rLastFill  <= 1'b1;
            oFillDone  <= 1'b0;
        end else begin
            state      <= state_next;
            rFillAddr  <= fill_addr_next;
            rFillColor <= fill_color_next;
            rLastFill  <= last_fill_next;
            oFillDone  <= fill_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        fill_addr_next  = rFillAddr;
        fill_color_next = rFillColor;
        last_fill_next  = rLastFill;
        fill_done_next  = 1'b0;
        slot_we         = 1'b0;
        slot_addr       = iCpuAddr;
        slot_data       = iCpuData;
        case (state)
            IDLE: begin
                slot_we = cpu_accept;
                if (iFillStart) begin
                    state_next      = FILL;
                    fill_addr_next  = '0;
                    fill_color_next = iFillColor;
                    last_fill_next  = ~cpu_accept;
                end
            end
            FILL: begin
                slot_we = 1'b1;
                if (cpu_accept) begin
                    last_fill_next = 1'b0;
                end else begin
                    slot_addr      = rFillAddr;
                    slot_data      = rFillColor;
                    fill_addr_next = rFillAddr + 1'b1;
                    last_fill_next = 1'b1;
                    if (rFillAddr == '1) begin
                        state_next     = IDLE;
                        fill_done_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
`else
    logic unused_fill;

    assign unused_fill = ^{iFillStart, iFillColor};
    assign oCpuReady   = 1'b1;
    assign oFillBusy   = 1'b0;
    assign oFillDone   = 1'b0;

    always_comb begin
        slot_we   = iCpuValid;
        slot_addr = iCpuAddr;
        slot_data = iCpuData;
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRamWriteEnable  <= 1'b0;
            oRamWriteAddress <= '0;
            oRamDataIn       <= '0;
        end else begin
            oRamWriteEnable <= slot_we;
            if (slot_we) begin
                oRamWriteAddress <= slot_addr;
                oRamDataIn       <= slot_data;
            end
        end
    end

    // One stage here plus the RAM's registered read gives the two-cycle valid delay.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRamReadAddress <= '0;
            pix_valid_d     <= 1'b0;
            oPixelValid     <= 1'b0;
        end else begin
            oRamReadAddress <= {iPixelY, iPixelX};
            pix_valid_d     <= iPixelValid;
            oPixelValid     <= pix_valid_d;
        end
    end

endmodule

// File: tb/tb_vram_controller.sv
// Self-checking bench for vram_controller: 16-bit instance for the main paths, 8-bit instance
// for the contended and simultaneous-start fill cases (fill cases need VRAM_FILL_EN).
module tb_vram_controller;
    localparam int DW  = 3;
    localparam int AW  = 16;
    localparam int CW  = AW / 2;
    localparam int BAW = 8;
    localparam int BCW = BAW / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          a_cpu_valid, a_cpu_ready, a_fill_start, a_fill_busy, a_fill_done;
    logic [AW-1:0] a_cpu_addr, a_waddr, a_raddr;
    logic [DW-1:0] a_cpu_data, a_fill_color, a_wdata;
    logic [CW-1:0] a_px, a_py;
    logic          a_pvalid_in, a_pvalid_out, a_we;

    logic           b_cpu_valid, b_cpu_ready, b_fill_start, b_fill_busy, b_fill_done;
    logic [BAW-1:0] b_cpu_addr, b_waddr, b_raddr;
    logic [DW-1:0]  b_cpu_data, b_fill_color, b_wdata;
    logic [BCW-1:0] b_px, b_py;
    logic           b_pvalid_in, b_pvalid_out, b_we;

    vram_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut_a (
        .Clock(clk), .Reset(rst_n),
        .iCpuValid(a_cpu_valid), .iCpuAddr(a_cpu_addr), .iCpuData(a_cpu_data), .oCpuReady(a_cpu_ready),
        .iFillStart(a_fill_start), .iFillColor(a_fill_color), .oFillBusy(a_fill_busy), .oFillDone(a_fill_done),
        .iPixelX(a_px), .iPixelY(a_py), .iPixelValid(a_pvalid_in), .oPixelValid(a_pvalid_out),
        .oRamWriteEnable(a_we), .oRamWriteAddress(a_waddr), .oRamDataIn(a_wdata), .oRamReadAddress(a_raddr)
    );

    vram_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(BAW)) u_dut_b (
        .Clock(clk), .Reset(rst_n),
        .iCpuValid(b_cpu_valid), .iCpuAddr(b_cpu_addr), .iCpuData(b_cpu_data), .oCpuReady(b_cpu_ready),
        .iFillStart(b_fill_start), .iFillColor(b_fill_color), .oFillBusy(b_fill_busy), .oFillDone(b_fill_done),
        .iPixelX(b_px), .iPixelY(b_py), .iPixelValid(b_pvalid_in), .oPixelValid(b_pvalid_out),
        .oRamWriteEnable(b_we), .oRamWriteAddress(b_waddr), .oRamDataIn(b_wdata), .oRamReadAddress(b_raddr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          pvalid;
        logic [AW-1:0] exp_raddr;
    } vec_t;

    wr_t           wq[$];
    bit            m_fill;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_color;
    logic          exp_done;
    logic [1:0]    pv_pipe;
    logic [AW-1:0] exp_raddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_fill   = 0;
        m_faddr  = '0;
        m_color  = '0;
        exp_done = 1'b0;
        pv_pipe  = 2'b00;
    endtask

    // Predict instance A across one edge, then compare every output.
    task automatic tick_a();
        wr_t e;
        if (a_cpu_valid) begin
            e.addr = a_cpu_addr;
            e.data = a_cpu_data;
            wq.push_back(e);
        end
        exp_done = 1'b0;
`ifdef VRAM_FILL_EN
        if (m_fill) begin
            e.addr = m_faddr;
            e.data = m_color;
            wq.push_back(e);
            if (m_faddr == '1) begin
                exp_done = 1'b1;
                m_fill   = 0;
            end
            m_faddr = m_faddr + 1'b1;
        end else if (a_fill_start) begin
            m_fill  = 1;
            m_faddr = '0;
            m_color = a_fill_color;
        end
`endif
        pv_pipe   = {pv_pipe[0], a_pvalid_in};
        exp_raddr = {a_py, a_px};
        @(posedge clk);
        #1;
        chk("cpu_ready", a_cpu_ready, 1);
        chk("fill_busy", a_fill_busy, m_fill);
        chk("fill_done", a_fill_done, exp_done);
        chk("read_addr", a_raddr, exp_raddr);
        chk("pixel_valid", a_pvalid_out, pv_pipe[1]);
        chk("write_en", a_we, wq.size() != 0);
        if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("write_addr", a_waddr, e.addr);
            chk("write_data", a_wdata, e.data);
        end
    endtask

    initial begin
        vec_t           vecs[8];
        logic [BAW-1:0] cpu_a, fa;
        logic           exp_rdy;
        int             done_cnt;

        vecs[0] = '{1'b1, 16'h1234, 3'd5, 8'h12, 8'h34, 1'b1, 16'h3412};
        vecs[1] = '{1'b0, 16'h0000, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 16'hFFFF, 3'd7, 8'hFF, 8'hFF, 1'b1, 16'hFFFF};
        vecs[3] = '{1'b1, 16'h0000, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 16'h8001, 3'd2, 8'h01, 8'h80, 1'b0, 16'h8001};
        vecs[5] = '{1'b0, 16'h5555, 3'd3, 8'hAB, 8'hCD, 1'b1, 16'hCDAB};
        vecs[6] = '{1'b1, 16'h00FF, 3'd6, 8'h7F, 8'h00, 1'b0, 16'h007F};
        vecs[7] = '{1'b0, 16'h0000, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000};

        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_cpu_valid = 1'($urandom); a_cpu_addr = AW'($urandom); a_cpu_data = DW'($urandom);
            a_fill_start = 1'($urandom); a_fill_color = DW'($urandom);
            a_px = CW'($urandom); a_py = CW'($urandom); a_pvalid_in = 1'($urandom);
            b_cpu_valid = 1'($urandom); b_cpu_addr = BAW'($urandom); b_cpu_data = DW'($urandom);
            b_fill_start = 1'($urandom); b_fill_color = DW'($urandom);
            b_px = BCW'($urandom); b_py = BCW'($urandom); b_pvalid_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_ready", a_cpu_ready, 1);
            chk("rst_busy", a_fill_busy, 0);
            chk("rst_done", a_fill_done, 0);
            chk("rst_pvalid", a_pvalid_out, 0);
            chk("rst_we", a_we, 0);
            chk("rst_waddr", a_waddr, 0);
            chk("rst_wdata", a_wdata, 0);
            chk("rst_raddr", a_raddr, 0);
            chk("rst_b_ready", b_cpu_ready, 1);
            chk("rst_b_busy", b_fill_busy, 0);
            chk("rst_b_done", b_fill_done, 0);
            chk("rst_b_pvalid", b_pvalid_out, 0);
            chk("rst_b_we", b_we, 0);
            chk("rst_b_wport", {b_waddr, b_wdata}, 0);
            chk("rst_b_raddr", b_raddr, 0);
        end
        a_cpu_valid = 0; a_cpu_addr = '0; a_cpu_data = '0; a_fill_start = 0; a_fill_color = '0;
        a_px = '0; a_py = '0; a_pvalid_in = 0;
        b_cpu_valid = 0; b_cpu_addr = '0; b_cpu_data = '0; b_fill_start = 0; b_fill_color = '0;
        b_px = '0; b_py = '0; b_pvalid_in = 0;
        model_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            a_cpu_valid = vecs[i].valid;
            a_cpu_addr  = vecs[i].addr;
            a_cpu_data  = vecs[i].data;
            a_px        = vecs[i].px;
            a_py        = vecs[i].py;
            a_pvalid_in = vecs[i].pvalid;
            tick_a();
            chk("vec_raddr", a_raddr, vecs[i].exp_raddr);
        end
        tick_a();
        tick_a();

`ifndef VRAM_FILL_EN
        a_fill_start = 1; a_fill_color = 3'd3;
        tick_a();
        a_fill_start = 0;
        for (int i = 0; i < 3; i++) tick_a();
`else
        // Contended fill on the narrow instance: CPU first, then strict alternation.
        b_fill_start = 1; b_fill_color = 3'd2; b_cpu_valid = 0;
        @(posedge clk);
        #1;
        chk("b_busy_start", b_fill_busy, 1);
        b_fill_start = 0; b_cpu_valid = 1; b_cpu_data = 3'd5;
        cpu_a = 8'h80; b_cpu_addr = cpu_a; fa = '0;
        for (int i = 0; i < 512; i++) begin
            exp_rdy = (i % 2 == 0);
            chk("b_ready_toggle", b_cpu_ready, exp_rdy);
            @(posedge clk);
            #1;
            chk("b_we", b_we, 1);
            if (exp_rdy) begin
                chk("b_cpu_waddr", b_waddr, cpu_a);
                chk("b_cpu_wdata", b_wdata, 5);
                cpu_a = cpu_a + 1'b1;
                b_cpu_addr = cpu_a;
            end else begin
                chk("b_fill_waddr", b_waddr, fa);
                chk("b_fill_wdata", b_wdata, 2);
                fa = fa + 1'b1;
            end
            chk("b_done", b_fill_done, i == 511);
            chk("b_busy", b_fill_busy, i != 511);
        end
        b_cpu_valid = 0;
        @(posedge clk);
        #1;
        chk("b_idle_we", b_we, 0);
        chk("b_idle_ready", b_cpu_ready, 1);

        // Simultaneous start: CPU write first, first FILL slot goes to the fill.
        b_cpu_valid = 1; b_cpu_addr = 8'h55; b_cpu_data = 3'd6; b_fill_start = 1; b_fill_color = 3'd1;
        @(posedge clk);
        #1;
        b_fill_start = 0;
        chk("sim_cpu_we", b_we, 1);
        chk("sim_cpu_waddr", b_waddr, 8'h55);
        chk("sim_cpu_wdata", b_wdata, 6);
        chk("sim_busy", b_fill_busy, 1);
        chk("sim_ready_low", b_cpu_ready, 0);
        b_cpu_addr = 8'h56;
        @(posedge clk);
        #1;
        chk("sim_fill_we", b_we, 1);
        chk("sim_fill_waddr", b_waddr, 8'h00);
        chk("sim_fill_wdata", b_wdata, 1);
        chk("sim_ready_high", b_cpu_ready, 1);
        @(posedge clk);
        #1;
        chk("sim_cpu2_waddr", b_waddr, 8'h56);
        chk("sim_cpu2_wdata", b_wdata, 6);
        b_cpu_valid = 0;
        done_cnt = 0;
        for (int i = 0; i < 600 && b_fill_busy; i++) begin
            @(posedge clk);
            #1;
            if (b_fill_done) done_cnt++;
        end
        chk("sim_fill_ends", b_fill_busy, 0);
        chk("sim_done_once", done_cnt, 1);

        // Full idle fill on the wide instance.
        a_fill_start = 1; a_fill_color = 3'd3;
        tick_a();
        a_fill_start = 0;
        for (int i = 0; i < 65536; i++) tick_a();
        tick_a();

        // Abort with rFillAddr at 0x0100, then restart from address 0.
        a_fill_start = 1; a_fill_color = 3'd4;
        tick_a();
        a_fill_start = 0;
        for (int i = 0; i < 256; i++) tick_a();
        chk("abort_pos", m_faddr, 16'h0100);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", a_fill_busy, 0);
        chk("abort_we", a_we, 0);
        chk("abort_done", a_fill_done, 0);
        chk("abort_ready", a_cpu_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        chk("abort_done_hold", a_fill_done, 0);
        rst_n = 1'b1;
        a_fill_start = 1; a_fill_color = 3'd6;
        tick_a();
        a_fill_start = 0;
        for (int i = 0; i < 4; i++) tick_a();
        #2 rst_n = 1'b0;
        #1;
        chk("abort2_busy", a_fill_busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_a();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_controller.md
# vram_controller

Front-end controller for the 256x256, 3-bit-per-pixel video RAM (one write port, one registered read port). Shares the single write port between a CPU pixel-write requester and a built-in screen-fill engine using alternating priority. Converts display scan coordinates into the RAM read address and tracks read-data validity through the RAM latency. Sits between the CPU/display timing logic and the video RAM instance.

## Interface

Parameters:
- DATA_WIDTH, 3, pixel width in bits.
- ADDR_WIDTH, 16, RAM address width. Must be even; each coordinate is ADDR_WIDTH/2 bits.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iCpuValid  in  1  CPU write request.
- iCpuAddr  in  ADDR_WIDTH  CPU write address.
- iCpuData  in  DATA_WIDTH  CPU write pixel.
- oCpuReady  out  1  CPU write slot available; a write is accepted on a rising edge where iCpuValid && oCpuReady.
- iFillStart  in  1  start-fill pulse.
- iFillColor  in  DATA_WIDTH  fill pixel, sampled with iFillStart.
- oFillBusy  out  1  fill in progress.
- oFillDone  out  1  one-cycle completion pulse.
- iPixelX, iPixelY  in  ADDR_WIDTH/2 each  display scan coordinates.
- iPixelValid  in  1  coordinates valid.
- oPixelValid  out  1  RAM read data valid for the matching coordinates.
- oRamWriteEnable  out  1  to RAM iWriteEnable.
- oRamWriteAddress  out  ADDR_WIDTH  to RAM iWriteAddress.
- oRamDataIn  out  DATA_WIDTH  to RAM iDataIn.
- oRamReadAddress  out  ADDR_WIDTH  to RAM iReadAddress.

## Operation

- FSM states: IDLE, FILL. Additional registers: fill counter rFillAddr (ADDR_WIDTH bits), latched colour, last-grant flag rLastFill.
- IDLE: oCpuReady = 1. If iFillStart is high, the FSM goes to FILL, rFillAddr := 0 and the colour is latched. rLastFill := 0 if a CPU write was accepted on the same edge, else 1.
- FILL: oCpuReady = rLastFill. oCpuReady is derived from registers only and never from iCpuValid.
  - If a CPU write is accepted, the CPU owns the slot and rLastFill := 0.
  - Otherwise the fill owns the slot: it writes {rFillAddr, colour}, rFillAddr increments, and rLastFill := 1.
  - Under continuous CPU demand, grants alternate CPU/fill. With no CPU demand, the fill writes every cycle.
- The FILL slot at rFillAddr = all-ones is the final fill write. On that edge the FSM returns to IDLE and rFillAddr wraps to 0.
- iFillStart is ignored while in FILL.
- oFillBusy = (state == FILL).
- Write port: oRamWriteEnable, oRamWriteAddress and oRamDataIn are registered from the slot winner. oRamWriteEnable is 0 when no slot is used.
- Read path: oRamReadAddress <= {iPixelY, iPixelX} every cycle. oPixelValid is iPixelValid delayed 2 cycles (1 cycle here + 1 cycle in the RAM).
- Reset asserted mid-fill: the FSM returns to IDLE immediately with no oFillDone pulse. RAM contents remain partially filled.

## Timing

- Reset values: all outputs 0, except oCpuReady = 1 (IDLE). State = IDLE, rFillAddr = 0, rLastFill = 1.
- CPU write latency: accepted at edge N → oRamWriteEnable high with the CPU address/data during cycle N+1 (edge N to N+1). The RAM commits the write at edge N+1.
- Fill with iFillStart sampled at edge 0 and no CPU traffic:
  - oFillBusy is high from edge 0 to edge 65536.
  - RAM writes to addresses 0..65535 appear during cycles 1..65536.
  - oFillDone is registered high for exactly one cycle, coincident with the address-65535 write.
- Fill under continuous iCpuValid: 131072 slots; fill writes occupy every second cycle.
- Read: coordinates at edge N → address valid after edge N → RAM data and oPixelValid valid after edge N+1.

## Configuration

- VRAM_FILL_EN defined: fill engine and arbitration compiled in as described above.
- VRAM_FILL_EN undefined:
  - No FSM, counter or colour register is built.
  - iFillStart and iFillColor are ignored.
  - oFillBusy and oFillDone are tied to 0.
  - oCpuReady is tied to 1, so every iCpuValid is a write.
- The read path is identical in both builds.

## Test plan

- Reset: hold Reset = 0 with random inputs → every output 0 except oCpuReady = 1. Release → the first CPU write to 0x1234, data 5 appears on the write port exactly one cycle after acceptance.
- Idle fill: iFillStart with colour 3, no CPU traffic → 65536 consecutive writes, addresses 0..0xFFFF, data 3. oFillDone is a single pulse with the 0xFFFF write. oFillBusy falls after that edge.
- Contended fill: iCpuValid held high through the fill → writes alternate CPU/fill, oCpuReady toggles every cycle, the fill completes after 131072 slots, and no CPU write is dropped or duplicated.
- Simultaneous start: in IDLE, iFillStart and an accepted CPU write on the same edge → the CPU write is issued first, then the first FILL slot belongs to the fill (address 0) even if iCpuValid is high.
- Abort: assert Reset at rFillAddr = 0x0100 → oFillBusy = 0 and oRamWriteEnable = 0 immediately, no oFillDone. A new iFillStart restarts from address 0.
- Read path: X = 0x12, Y = 0x34 with iPixelValid → oRamReadAddress = 0x3412 one cycle later, oPixelValid high two cycles later. Repeat with VRAM_FILL_EN undefined and check that oCpuReady stays at 1 throughout.
